// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// -----------------------------------------------------------------------------
// Byte buffer that sits directly in front of the debug-console UART transmitter.
// Console writes arrive in bursts on the write side, are queued here, and are
// drained one byte at a time over a valid/ready interface. Writes offered while
// the buffer is full are refused by back-pressure, and the attempt is recorded
// in a sticky overflow flag.
//
// Optional feature (macro UART_TX_FIFO_CRLF_EN):
//   When defined, a line feed (0x0A) at the head of the queue is sent as
//   CR (0x0D) followed by LF (0x0A). The CR is generated by the output stage
//   and never occupies a storage slot.
//
// Parameters:
//   DATA_WIDTH  width of each entry (default 8)
//   DEPTH       number of entries, power of two, >= 2 (default 16)
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_wr_data       byte from console writer
//   i_wr_valid      writer offers i_wr_data
//   o_wr_ready      buffer can accept a byte this cycle
//   o_tx_data       byte presented to transmitter (0 while empty)
//   o_tx_valid      o_tx_data is valid
//   i_tx_ready      transmitter accepts o_tx_data this cycle
//   o_level         current occupancy in entries
//   o_empty         occupancy == 0
//   o_full          occupancy == DEPTH
//   o_overflow      sticky: a write was attempted while full
//   i_clr_overflow  clears o_overflow
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    output logic [DATA_WIDTH-1:0]        o_tx_data,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_overflow,
    input  logic                         i_clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  overflow;

    logic                  push;
    logic                  handshake;
    logic                  pop;
    logic                  pop_en;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tx_data_c;

    // Extra pointer MSB: equal pointers mean empty, pointers differing only
    // in the MSB mean full. Both flags depend on registered state only, so
    // o_wr_ready has no path from i_tx_ready.
    assign o_empty    = (wr_ptr == rd_ptr);
    assign o_full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign o_wr_ready = !o_full;
    assign o_tx_valid = !o_empty;
    assign o_level    = level;
    assign o_overflow = overflow;

    assign push      = i_wr_valid && !o_full;
    assign handshake = o_tx_valid && i_tx_ready;
    assign pop       = handshake && pop_en;
    assign head      = mem[rd_ptr[AW-1:0]];

    // Output is forced to zero while empty so it never shows stale storage.
    assign o_tx_data = o_empty ? '0 : tx_data_c;

`ifdef UART_TX_FIFO_CRLF_EN
    typedef enum logic {
        PASS,
        EMIT_CR
    } crlf_state_t;

    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'(8'h0D);

    crlf_state_t state;
    logic        inject_cr;

    // In PASS with LF at the head, the CR is shown instead and the LF stays
    // queued; after the CR is taken, EMIT_CR shows the LF and pops it.
    assign inject_cr = (state == PASS) && (head == LF);
    assign tx_data_c = inject_cr ? CR : head;
    assign pop_en    = !inject_cr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= PASS;
        end else if (handshake) begin
            case (state)
                PASS:    if (head == LF) state <= EMIT_CR;
                EMIT_CR: state <= PASS;
                default: state <= PASS;
            endcase
        end
    end
`else
    assign tx_data_c = head;
    assign pop_en    = 1'b1;
`endif

    // Storage holds no reset: contents are only visible once written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A write attempt while full takes priority over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow <= 1'b0;
        end else if (i_wr_valid && o_full) begin
            overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the debug-console UART transmitter.
- Absorbs bursts of console writes from the MMIO/console path and drains them one byte at a time over a valid/ready interface.
- Keeps software from stalling on every character.
- Drops nothing silently: writes while full are refused by back-pressure, and a sticky overflow flag records any write attempted while full.

Parameters:
- DATA_WIDTH, 8, width of each byte/entry.
- DEPTH, 16, number of entries; must be a power of two, at least 2.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_wr_data  input  DATA_WIDTH  byte from console writer
- i_wr_valid  input  1  writer offers i_wr_data
- o_wr_ready  output  1  FIFO can accept a byte this cycle
- o_tx_data  output  DATA_WIDTH  byte presented to transmitter
- o_tx_valid  output  1  o_tx_data is valid
- i_tx_ready  input  1  transmitter accepts o_tx_data this cycle
- o_level  output  $clog2(DEPTH+1)  current occupancy
- o_empty  output  1  occupancy == 0
- o_full  output  1  occupancy == DEPTH
- o_overflow  output  1  sticky: write attempted while full
- i_clr_overflow  input  1  clears o_overflow

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst_n, asynchronous and active-low. All state clears immediately on assertion; release is synchronous to i_clk.
- Reset values: o_wr_ready=1, o_tx_valid=0, o_level=0, o_empty=1, o_full=0, o_overflow=0, o_tx_data=0.
- Storage and pointers:
  - Storage is a DEPTH-entry array.
  - Read/write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH with no special casing.
- Push: occurs when i_wr_valid && o_wr_ready. Data is written at wr_ptr, and wr_ptr increments.
- Pop: occurs when o_tx_valid && i_tx_ready. rd_ptr increments.
- Ready, valid and data outputs:
  - o_wr_ready = !o_full, from registered state only, with no combinational path from i_tx_ready.
  - o_tx_valid = !o_empty.
  - o_tx_data = entry at rd_ptr, stable while o_tx_valid && !i_tx_ready.
- Latency: a byte pushed in cycle N is visible at o_tx_valid/o_tx_data in cycle N+1. No fall-through in the same cycle.
- Simultaneous push and pop:
  - When not full and not empty, both occur and o_level is unchanged.
  - When full, the push is refused even if a pop happens the same cycle; the writer retries next cycle.
  - When empty, no pop is possible and the push proceeds.
- o_level is a registered counter updated as +1 on push only, -1 on pop only, and unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Overflow:
  - o_overflow sets the cycle after any cycle with i_wr_valid && o_full.
  - i_clr_overflow clears it.
  - If set and clear coincide, set wins.
- Reset mid-operation: all queued bytes are discarded, pointers return to 0, and o_tx_valid drops asynchronously. A transmitter already mid-frame is unaffected, because it has already captured its byte.
- Data handling: bytes are emitted in write order, with unchanged contents except as the optional feature below specifies.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN.
- When defined, the output stage is a 2-state FSM, PASS and EMIT_CR, for LF (0x0A) at the FIFO head:
  - PASS with head == 0x0A: the block presents 0x0D with o_tx_valid=1 and does not pop. On handshake it moves to EMIT_CR.
  - EMIT_CR: the block presents 0x0A. On handshake it pops and returns to PASS.
  - PASS with any other head byte: the byte is presented and popped normally.
  - The FSM resets to PASS. o_level counts only FIFO entries; the injected CR does not occupy a slot.
- When undefined: no FSM; every byte passes through unchanged, including 0x0A.

Test Plan:
- Reset then write 0x41,0x42,0x43 with i_tx_ready=1 -> o_tx_data 0x41,0x42,0x43 in order; first o_tx_valid one cycle after first push; o_level returns to 0.
- i_tx_ready=0, write 16 bytes 0x00..0x0F -> o_full=1, o_wr_ready=0, o_level=16. A 17th write (0xFF) is refused and o_overflow=1 next cycle. Then drain -> exactly 0x00..0x0F emitted.
- Full FIFO with i_wr_valid=1 and i_tx_ready=1 in the same cycle -> pop occurs, push refused, o_level 15. Push accepted the next cycle, o_level 16.
- Pointer wrap: 40 bytes streamed with random i_tx_ready stalls -> all 40 bytes out in order, and o_tx_data holds steady during every stall.
- Assert i_rst_n=0 mid-burst with o_level=5 -> o_tx_valid=0 and o_level=0 immediately, without waiting for a clock edge. After release, a new write 0x55 is emitted alone.
- With UART_TX_FIFO_CRLF_EN, write 0x48,0x0A -> output 0x48,0x0D,0x0A. Without the macro -> output 0x48,0x0A.
